router_out_fifo: RTL and testbench
==================================

# router_out_fifo

Per-destination output buffer of the 1x3 router. It sits directly downstream of the router register stage and captures that stage's 8-bit output byte stream into a 16-deep FIFO, tagging each entry with the header marker (`lfd_state`). On the read side it delivers bytes to the destination with one cycle of registered latency. It tracks the remaining packet length from the header so it can idle its output after the parity byte.

## Interface
- `DEPTH`, 16: number of entries; a power of two.
- `WIDTH`, 8: data byte width. Each stored entry is WIDTH+1 bits: the data byte plus a header-marker bit.
- `clock`  in  1  single clock; all state changes on its rising edge.
- `resetn`  in  1  reset, asynchronous and active-low.
- `soft_reset`  in  1  synchronous flush driven by the router FSM timeout; active-high.
- `write_enb`  in  1  write request from the router FSM/synchronizer.
- `lfd_state`  in  1  the byte written this cycle is a header; stored as bit WIDTH of the entry.
- `data_in`  in  WIDTH  byte from the register stage (its `dout`).
- `read_enb`  in  1  read request from the destination.
- `full`  out  1  all DEPTH entries occupied.
- `empty`  out  1  no entries occupied.
- `data_out`  out  WIDTH  registered read data.

## Operation
- Storage: DEPTH x (WIDTH+1) array.
- Write and read pointers are log2(DEPTH)+1 bits wide, where the MSB is a wrap bit.
  - `empty` = pointers equal.
  - `full` = low bits equal and wrap bits differ.
  - Both are combinational from the pointers.
- Write: when `write_enb && !full`, store {`lfd_state`, `data_in`} at the write pointer's low bits and increment the write pointer.
  - A write while full is dropped; no pointer change.
- Read: when `read_enb && !empty`:
  - `data_out` <= entry[WIDTH-1:0].
  - Increment the read pointer.
- Packet counter `pkt_cnt`, 7 bits, internal:
  - On a read of an entry with the marker bit set: `pkt_cnt` <= entry[7:2] + 1 (payload length plus parity byte).
  - On a read of a non-header entry with `pkt_cnt` != 0: decrement `pkt_cnt`.
  - A read of a non-header entry with `pkt_cnt` == 0 delivers data but leaves `pkt_cnt` at 0.
- Idle output: on any cycle with no read and `pkt_cnt` == 0, `data_out` <= 0. Otherwise, with no read, `data_out` holds.
- Read while empty: ignored; pointers unchanged; the idle-output rule still applies.
- Simultaneous read and write:
  - Both proceed when neither is blocked.
  - When full, the read proceeds and the write is dropped, because `full` is sampled before the edge.
  - When empty, the write proceeds and the read is ignored.
- `soft_reset`, priority over read and write:
  - Pointers to 0 and `pkt_cnt` to 0.
  - `data_out` to 0.
  - The same-cycle write and read are discarded.
  - Array contents are don't-care.
- `resetn` low, at any time including mid-packet:
  - Immediately clears the pointers, `pkt_cnt` and `data_out`.
  - `full` = 0 and `empty` = 1 while reset is asserted and after release.

## Timing
- Reset values: `data_out` = 0, `full` = 0, `empty` = 1.
- Write-to-flag latency: `empty` falls the cycle after the first accepted write edge. `full` rises after the DEPTH-th accepted write.
- Read latency: `data_out` is valid 1 cycle after the edge at which `read_enb && !empty` is sampled.
- Last byte: the parity byte stays on `data_out` for the cycle after its read edge. It goes to 0 at the following edge if no read occurs.
- Wrap-around: the pointers wrap modulo 2*DEPTH with no bubble; DEPTH consecutive writes then DEPTH reads leave the FIFO empty with wrap bits equal.
- Throughput: one write and one read per cycle sustained.
- `soft_reset` takes effect at the edge it is sampled. Flags are correct (`empty` = 1) from the next cycle.

## Test plan
- Reset/basic: assert `resetn` = 0 mid-cycle.
  - Flags go to `empty` = 1, `full` = 0 and `data_out` = 0 asynchronously.
  - Write header 0x0D (lfd = 1, length 3), then 0x11, 0x22, 0x33, then parity 0x0F.
  - Read all: `data_out` = 0x0D, 0x11, 0x22, 0x33, 0x0F on consecutive cycles, then 0x00 on the next idle cycle.
- Full/overflow: 16 writes of 0x01..0x10.
  - `full` = 1 after the 16th write.
  - A 17th write of 0xFF is dropped.
  - 16 reads return 0x01..0x10; `empty` = 1.
- Simultaneous read/write at full: one cycle with both enables high.
  - Read returns the oldest byte.
  - The write is dropped.
  - Occupancy becomes 15 and `full` = 0.
- Wrap-around: 10 writes, 10 reads, then 16 writes, then 16 reads.
  - Data order preserved.
  - `full` asserts exactly after the 16th write of the second burst.
- Soft reset mid-packet: header 0x15 (length 5), 3 bytes read, assert `soft_reset` with `write_enb` high.
  - Next cycle `empty` = 1 and `data_out` = 0.
  - The write is discarded.
  - The next header read reloads `pkt_cnt` correctly.

Source files
------------

// File: rtl/router_out_fifo_if.sv
// Byte-stream bus between the router core and one destination output buffer.
interface router_out_fifo_if #(
  parameter int unsigned WIDTH = 8
);
  logic             soft_reset;
  logic             write_enb;
  logic             lfd_state;
  logic [WIDTH-1:0] data_in;
  logic             read_enb;
  logic             full;
  logic             empty;
  logic [WIDTH-1:0] data_out;

  modport master (
    output soft_reset, write_enb, lfd_state, data_in, read_enb,
    input  full, empty, data_out
  );

  modport slave (
    input  soft_reset, write_enb, lfd_state, data_in, read_enb,
    output full, empty, data_out
  );
endinterface

// File: rtl/router_out_fifo.sv
// Per-destination output FIFO of the 1x3 router: header-tagged storage, registered
// read data, and a packet-length counter that idles data_out after the parity byte.
module router_out_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic              clock,
  input  logic              resetn,
  router_out_fifo_if.slave  bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned EW = WIDTH + 1;
  localparam int unsigned CW = 7;

  logic [EW-1:0]    mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    pkt_cnt_q, pkt_cnt_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;

  logic             full_c;
  logic             empty_c;
  logic             wr_acc_c;
  logic             rd_acc_c;
  logic [EW-1:0]    rd_entry_c;

  assign empty_c    = (wr_ptr_q == rd_ptr_q);
  assign full_c     = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign wr_acc_c   = bus.write_enb && !full_c;
  assign rd_acc_c   = bus.read_enb && !empty_c;
  assign rd_entry_c = mem_q[rd_ptr_q[AW-1:0]];

  // Next-state for pointers, packet counter and output register; soft_reset wins.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    pkt_cnt_d  = pkt_cnt_q;
    data_out_d = data_out_q;
    if (bus.soft_reset) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      pkt_cnt_d  = '0;
      data_out_d = '0;
    end else begin
      if (wr_acc_c) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (rd_acc_c) begin
        rd_ptr_d   = rd_ptr_q + PW'(1);
        data_out_d = rd_entry_c[WIDTH-1:0];
        if (rd_entry_c[WIDTH]) begin
          // Header length field plus the trailing parity byte.
          pkt_cnt_d = CW'(rd_entry_c[WIDTH-1:2]) + CW'(1);
        end else if (pkt_cnt_q != '0) begin
          pkt_cnt_d = pkt_cnt_q - CW'(1);
        end
      end else if (pkt_cnt_q == '0) begin
        data_out_d = '0;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      pkt_cnt_q  <= '0;
      data_out_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      pkt_cnt_q  <= pkt_cnt_d;
      data_out_q <= data_out_d;
    end
  end

  // Storage is not reset; contents behind the read pointer are never observed.
  always_ff @(posedge clock) begin
    if (wr_acc_c && !bus.soft_reset) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {bus.lfd_state, bus.data_in};
    end
  end

  assign bus.full     = full_c;
  assign bus.empty    = empty_c;
  assign bus.data_out = data_out_q;

endmodule

// File: tb/tb_router_out_fifo.sv
// Scoreboard bench for router_out_fifo: a queue-based reference model predicts the
// post-edge outputs of every cycle and a negedge monitor compares them.
module tb_router_out_fifo;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned WIDTH = 8;

  typedef struct packed {
    logic [7:0] dout;
    logic       full;
    logic       empty;
  } exp_t;

  logic clock;
  logic resetn;

  router_out_fifo_if #(.WIDTH(WIDTH)) bus ();

  router_out_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int tests  = 0;
  int failed = 0;

  logic [8:0] mq[$];
  int         m_pkt  = 0;
  logic [7:0] m_dout = 8'h00;
  exp_t       exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: compares each cycle's predicted post-edge state.
  always @(negedge clock) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("data_out", 32'(bus.data_out), 32'(e.dout));
      check("full",     32'(bus.full),     32'(e.full));
      check("empty",    32'(bus.empty),    32'(e.empty));
    end
  end

  // One clock cycle of stimulus; called just after a negedge.
  task automatic cycle(input logic we, input logic lfd, input logic [7:0] din,
                       input logic re, input logic sr);
    exp_t e;
    logic [8:0] ent;
    bit m_full, m_empty;
    bus.write_enb  = we;
    bus.lfd_state  = lfd;
    bus.data_in    = din;
    bus.read_enb   = re;
    bus.soft_reset = sr;
    m_full  = (mq.size() == DEPTH);
    m_empty = (mq.size() == 0);
    if (sr) begin
      mq.delete();
      m_pkt  = 0;
      m_dout = 8'h00;
    end else begin
      if (re && !m_empty) begin
        ent    = mq.pop_front();
        m_dout = ent[7:0];
        if (ent[8])          m_pkt = int'(ent[7:2]) + 1;
        else if (m_pkt != 0) m_pkt = m_pkt - 1;
      end else if (m_pkt == 0) begin
        m_dout = 8'h00;
      end
      if (we && !m_full) mq.push_back({lfd, din});
    end
    e.dout  = m_dout;
    e.full  = (mq.size() == DEPTH);
    e.empty = (mq.size() == 0);
    @(posedge clock);
    #1 exp_q.push_back(e);
    @(negedge clock);
  endtask

  task automatic wr(input logic lfd, input logic [7:0] d);
    cycle(1'b1, lfd, d, 1'b0, 1'b0);
  endtask

  task automatic rd();
    cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  // Asynchronous reset asserted in the middle of a clock-high phase.
  task automatic mid_reset();
    @(posedge clock);
    #2 resetn = 1'b0;
    #1;
    check("rst data_out", 32'(bus.data_out), 32'h0);
    check("rst empty",    32'(bus.empty),    32'h1);
    check("rst full",     32'(bus.full),     32'h0);
    mq.delete();
    m_pkt  = 0;
    m_dout = 8'h00;
    @(negedge clock);
    resetn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn         = 1'b0;
    bus.soft_reset = 1'b0;
    bus.write_enb  = 1'b0;
    bus.lfd_state  = 1'b0;
    bus.data_in    = 8'h00;
    bus.read_enb   = 1'b0;
    repeat (2) @(negedge clock);
    resetn = 1'b1;

    // Reset mid-packet, then one full packet with idle afterwards.
    wr(1'b1, 8'h0D);
    wr(1'b0, 8'h11);
    rd();
    mid_reset();
    wr(1'b1, 8'h0D);
    wr(1'b0, 8'h11);
    wr(1'b0, 8'h22);
    wr(1'b0, 8'h33);
    wr(1'b0, 8'h0F);
    rd(); rd(); rd(); rd(); rd();
    check("parity held", 32'(bus.data_out), 32'h0F);
    idle();
    check("idle after parity", 32'(bus.data_out), 32'h00);
    idle();

    // Full and overflow.
    for (int i = 1; i <= 16; i++) wr(1'b0, 8'(i));
    check("full after 16", 32'(bus.full), 32'h1);
    wr(1'b0, 8'hFF);
    // Simultaneous read/write while full: read proceeds, write dropped.
    cycle(1'b1, 1'b0, 8'hEE, 1'b1, 1'b0);
    check("rw at full data", 32'(bus.data_out), 32'h01);
    check("rw at full flag", 32'(bus.full), 32'h0);
    for (int i = 0; i < 15; i++) rd();
    check("drained empty", 32'(bus.empty), 32'h1);
    idle();

    // Wrap-around with unaligned pointers.
    for (int i = 0; i < 10; i++) wr(1'b0, 8'(8'h40 + i));
    for (int i = 0; i < 10; i++) rd();
    for (int i = 0; i < 16; i++) begin
      wr(1'b0, 8'(8'h80 + i));
      if (i == 14) check("not full at 15", 32'(bus.full), 32'h0);
    end
    check("full at 16 wrap", 32'(bus.full), 32'h1);
    for (int i = 0; i < 16; i++) rd();
    idle();

    // Soft reset mid-packet with a concurrent write.
    wr(1'b1, 8'h15);
    for (int i = 0; i < 6; i++) wr(1'b0, 8'(8'hA0 + i));
    rd(); rd(); rd();
    cycle(1'b1, 1'b0, 8'h77, 1'b1, 1'b1);
    check("sr empty", 32'(bus.empty), 32'h1);
    check("sr data_out", 32'(bus.data_out), 32'h0);
    wr(1'b1, 8'h09);
    wr(1'b0, 8'h5A);
    wr(1'b0, 8'hA5);
    wr(1'b0, 8'h3C);
    rd(); rd(); rd(); rd(); idle(); idle();

    // Randomized traffic with occasional flushes.
    for (int n = 0; n < 2000; n++) begin
      logic we, re, lfd, sr;
      we  = ($urandom_range(0, 99) < 55);
      re  = ($urandom_range(0, 99) < 50);
      lfd = ($urandom_range(0, 7) == 0);
      sr  = ($urandom_range(0, 199) == 0);
      cycle(we, lfd, 8'($urandom), re, sr);
    end
    idle();
    @(negedge clock);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
